shift_cmd_sequencer: RTL and testbench

//  Upstream command stage for barrel_shifter. Queues shift commands (data, op, amount) through a

---
 rtl/shift_cmd_sequencer_pkg.sv | 21 ++
 rtl/shift_cmd_sequencer_cmd_fifo.sv | 50 +++++
 rtl/shift_cmd_sequencer.sv | 120 ++++++++++++
 tb/tb_shift_cmd_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_cmd_sequencer_pkg.sv
// Shared definitions for the shift command sequencer.
// Holds the shifter opcodes the sequencer treats specially and the FSM
// state encoding. It also provides a helper that identifies load-only commands.
package shift_cmd_sequencer_pkg;

  localparam logic [3:0] OP_LOAD = 4'b0100;
  localparam logic [3:0] OP_HOLD = 4'b0101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

  // LOAD/HOLD commands only load the operand; their amount is ignored.
  function automatic logic is_load_only(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_HOLD);
  endfunction

endpackage

// File: rtl/shift_cmd_sequencer_cmd_fifo.sv
// Show-ahead synchronous command FIFO.
// Ports:
//   clk, rst_n   clock, async active-low reset (clears pointers/count)
//   push, din    write din when push && !full
//   pop, dout    dout is the head entry; pop advances when !empty
//   full, empty  occupancy flags
module shift_cmd_sequencer_cmd_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Command stage in front of a barrel shifter.
// Commands (op, amt, data) are queued and replayed onto the shifter as one
// LOAD step. This is followed by ceil(amt/SMAX) shift steps of at most SMAX each.
// The shifter's registered output is then captured as a one-cycle strobe.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake (cmd_ready = !full)
//   cmd_op, cmd_amt, cmd_data       command fields
//   sh_datain, sh_op, sh_s          drive barrel_shifter inputs
//   sh_dataout                      barrel_shifter registered output
//   res_valid, res_data             result strobe, data held until next strobe
//   busy                            command in flight or queued
module shift_cmd_sequencer
  import shift_cmd_sequencer_pkg::*;
#(
  parameter int N     = 5,
  parameter int DEPTH = 4,
  parameter int AMT_W = 3,
  parameter int S_W   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [N-1:0]     cmd_data,
  output logic [N-1:0]     sh_datain,
  output logic [3:0]       sh_op,
  output logic [S_W-1:0]   sh_s,
  input  logic [N-1:0]     sh_dataout,
  output logic             res_valid,
  output logic [N-1:0]     res_data,
  output logic             busy
);
  localparam int FW = 4 + AMT_W + N;
  localparam logic [AMT_W-1:0] SMAX = AMT_W'((1 << S_W) - 1);

  state_e           state;
  logic [3:0]       op_r;
  logic [AMT_W-1:0] rem_r;
  logic [N-1:0]     data_r;

  logic             fifo_full, fifo_empty, push, pop;
  logic [FW-1:0]    fifo_dout;
  logic [3:0]       head_op;
  logic [AMT_W-1:0] head_amt;
  logic [N-1:0]     head_data;
  logic [AMT_W-1:0] chunk, rem_next;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign {head_op, head_amt, head_data} = fifo_dout;

  shift_cmd_sequencer_cmd_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({cmd_op, cmd_amt, cmd_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Largest chunk the shifter can take this step; never exceeds rem_r.
  assign chunk    = (rem_r > SMAX) ? SMAX : rem_r;
  assign rem_next = rem_r - chunk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_r      <= OP_HOLD;
      rem_r     <= '0;
      data_r    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        ST_IDLE: if (!fifo_empty) begin
          op_r   <= head_op;
          rem_r  <= head_amt;
          data_r <= head_data;
          state  <= ST_LOAD;
        end
        ST_LOAD:
          state <= (!is_load_only(op_r) && rem_r != '0) ? ST_SHIFT : ST_CAPTURE;
        ST_SHIFT: begin
          rem_r <= rem_next;
          if (rem_next == '0) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // Shifter's last step landed on the previous edge; its output is final.
          res_data  <= sh_dataout;
          res_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sh_op     = OP_HOLD;
    sh_s      = '0;
    sh_datain = data_r;
    case (state)
      ST_LOAD:  sh_op = OP_LOAD;
      ST_SHIFT: begin
        sh_op = op_r;
        sh_s  = S_W'(chunk);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Bench for shift_cmd_sequencer driving a behavioural barrel shifter.
module tb_shift_cmd_sequencer;
  import shift_cmd_sequencer_pkg::*;

  localparam int N = 5;
  localparam int AMT_W = 3;
  localparam int S_W = 2;

  localparam logic [3:0] OP_ROR = 4'b0001;
  localparam logic [3:0] OP_SHL = 4'b0010;
  localparam logic [3:0] OP_SHR = 4'b0011;
  localparam logic [3:0] OP_ROL = 4'b1000;
  localparam logic [3:0] OP_ASR = 4'b1011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [3:0] cmd_op = '0;
  logic [AMT_W-1:0] cmd_amt = '0;
  logic [N-1:0] cmd_data = '0;
  logic [N-1:0] sh_datain, sh_dataout, res_data;
  logic [3:0] sh_op;
  logic [S_W-1:0] sh_s;
  logic res_valid, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [N-1:0] data;
    int acc;
    int k;
    bit chk_lat;
  } exp_t;
  exp_t exp_q[$];
  logic [S_W-1:0] s_seen[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  shift_cmd_sequencer #(.N(N), .DEPTH(4), .AMT_W(AMT_W), .S_W(S_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data),
    .sh_datain(sh_datain), .sh_op(sh_op), .sh_s(sh_s),
    .sh_dataout(sh_dataout),
    .res_valid(res_valid), .res_data(res_data), .busy(busy)
  );

  // Behavioural barrel shifter: one registered step per cycle, no reset.
  function automatic logic [N-1:0] sh_step(input logic [N-1:0] q, input logic [3:0] op,
                                           input logic [N-1:0] din, input logic [S_W-1:0] s);
    logic [2*N-1:0] dbl;
    dbl = {q, q};
    case (op)
      OP_LOAD: return din;
      OP_ROR:  begin dbl = dbl >> s; return dbl[N-1:0]; end
      OP_ROL:  begin dbl = dbl << s; return dbl[2*N-1:N]; end
      OP_SHL:  return q << s;
      OP_SHR:  return q >> s;
      OP_ASR:  return N'($signed(q) >>> s);
      default: return q;
    endcase
  endfunction

  logic [N-1:0] sh_q = 5'b10101;
  always @(posedge clk) sh_q <= sh_step(sh_q, sh_op, sh_datain, sh_s);
  assign sh_dataout = sh_q;

  // Reference: whole command applied in one go using the total amount.
  function automatic logic [N-1:0] ref_res(input logic [3:0] op, input int amt,
                                           input logic [N-1:0] d);
    logic [N-1:0] r;
    r = d;
    case (op)
      OP_ROR: for (int i = 0; i < amt % N; i++) r = {r[0], r[N-1:1]};
      OP_ROL: for (int i = 0; i < amt % N; i++) r = {r[N-2:0], r[N-1]};
      OP_SHL: r = (amt >= N) ? '0 : N'(d << amt);
      OP_SHR: r = (amt >= N) ? '0 : N'(d >> amt);
      OP_ASR: r = (amt >= N) ? {N{d[N-1]}} : N'($signed(d) >>> amt);
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic int k_of(input logic [3:0] op, input int amt);
    if (op == OP_LOAD || op == OP_HOLD) return 0;
    return (amt + 2) / 3;
  endfunction

  task automatic push(input logic [3:0] op, input logic [AMT_W-1:0] amt,
                      input logic [N-1:0] d, input bit chk);
    exp_t e;
    int guard;
    guard = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt; cmd_data = d;
    while (!cmd_ready && guard < 200) begin @(negedge clk); guard++; end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL push_timeout: cmd_ready stuck at 0, required 1");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    e.data = ref_res(op, int'(amt), d);
    e.acc = cyc;
    e.k = k_of(op, int'(amt));
    e.chk_lat = chk;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 300) begin @(negedge clk); guard++; end
    check({name, "_drained"}, {30'(exp_q.size()), busy}, 0);
  endtask

  // Scoreboard monitor: pops on every result strobe.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_result: res_valid=1 data=%b, required no strobe", res_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        tests++;
        if (res_data !== e.data) begin
          fails++;
          $display("FAIL res_data: got %b, required %b", res_data, e.data);
        end
        if (e.chk_lat) begin
          tests++;
          if (cyc - e.acc != 3 + e.k) begin
            fails++;
            $display("FAIL latency: got %0d edges, required %0d", cyc - e.acc, 3 + e.k);
          end
        end
      end
    end
  end

  always @(negedge clk)
    if (rst_n && sh_op != OP_LOAD && sh_op != OP_HOLD) s_seen.push_back(sh_s);

  localparam logic [18:0] RST_VEC = {OP_HOLD, 2'b00, 5'b0, 1'b0, 5'b0, 1'b0, 1'b1};

  initial begin
    logic [3:0] ops [7];
    int guard;
    ops = '{OP_ROR, OP_SHL, OP_SHR, OP_ROL, OP_ASR, OP_LOAD, OP_HOLD};

    #12;
    check("reset_outputs", {sh_op, sh_s, sh_datain, res_valid, res_data, busy, cmd_ready}, RST_VEC);
    @(negedge clk); rst_n = 1'b1;

    // Directed cases with latency checks
    s_seen.delete();
    push(OP_ROL, 3'd2, 5'b01010, 1);
    wait_drain("t1");
    check("t1_s_count", s_seen.size(), 1);
    if (s_seen.size() == 1) check("t1_s0", s_seen[0], 2);

    s_seen.delete();
    push(OP_ROL, 3'd7, 5'b01010, 1);
    wait_drain("t2");
    check("t2_s_count", s_seen.size(), 3);
    if (s_seen.size() == 3) check("t2_s_seq", {s_seen[0], s_seen[1], s_seen[2]}, {2'd3, 2'd3, 2'd1});

    push(OP_ASR, 3'd5, 5'b10010, 1);
    wait_drain("t3a");
    push(OP_SHL, 3'd1, 5'b10000, 1);
    wait_drain("t3b");

    s_seen.delete();
    push(OP_LOAD, 3'd5, 5'b10110, 1);
    wait_drain("t4");
    check("t4_no_shift", s_seen.size(), 0);

    // Fill the FIFO back-to-back behind a long command
    for (int i = 0; i < 5; i++) push(OP_ROL, 3'd7, N'(i + 3), 0);
    check("t5_full_ready", cmd_ready, 0);
    check("t5_busy", busy, 1);
    wait_drain("t5");
    @(negedge clk);
    check("t5_idle_busy", busy, 0);

    // Reset in the middle of a SHIFT
    push(OP_ROL, 3'd7, 5'b11001, 0);
    guard = 0;
    while (sh_op != OP_ROL && guard < 20) begin @(negedge clk); guard++; end
    check("t6_reached_shift", sh_op, OP_ROL);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_reset_outputs", {sh_op, sh_s, sh_datain, res_valid, res_data, busy, cmd_ready}, RST_VEC);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    push(OP_ROR, 3'd1, 5'b00011, 1);
    wait_drain("t6");

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      push(ops[$urandom_range(0, 6)], AMT_W'($urandom_range(0, 7)), N'($urandom), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
